// File: rtl/secded_decoder_seq.sv
// Two-stage SECDED decoder for 72-bit codewords {check[7:0], data[63:0]}; corrects single-bit errors and flags uncorrectable ones.
// Latency 2 cycles, one word per cycle; valid/ready backpressure with in_ready = !s1 || !s2 || out_ready.
package SECDED_ECC_pkg;

    // Hsiao-style columns: the first 64 byte values of odd weight 3 or 5, so every double error has an even, unmatched syndrome.
    function automatic logic [63:0][7:0] gen_cols();
        logic [63:0][7:0] cols;
        int n;
        int w;
        cols = '0;
        n = 0;
        for (int v = 1; v < 256; v++) begin
            w = 0;
            for (int b = 0; b < 8; b++) begin
                w = w + ((v >> b) & 1);
            end
            if ((w == 3 || w == 5) && n < 64) begin
                cols[n] = 8'(v);
                n = n + 1;
            end
        end
        return cols;
    endfunction

    localparam logic [63:0][7:0] H_DATA = gen_cols();

    function automatic logic [7:0] mega_xor(input logic [63:0] d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (d[i]) begin
                r = r ^ H_DATA[i];
            end
        end
        return r;
    endfunction

endpackage

module secded_decoder_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [71:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_ce,
    output logic             out_ue,
    output logic [7:0]       out_syndrome,
    output logic [CNT_W-1:0] ce_count,
    output logic [CNT_W-1:0] ue_count,
    output logic [7:0]       first_ue_syn,
    output logic             ue_seen,
    input  logic             cnt_clr
);

    logic             r_s1_vld;
    logic [71:0]      r_s1_code;
    logic [7:0]       r_s1_syn;

    logic             r_s2_vld;
    logic [63:0]      r_out_data;
    logic             r_out_ce;
    logic             r_out_ue;
    logic [7:0]       r_out_syn;

    logic [CNT_W-1:0] r_ce_cnt;
    logic [CNT_W-1:0] r_ue_cnt;
    logic [7:0]       r_first_syn;
    logic             r_ue_seen;

    logic [7:0]       w_in_syn;
    logic             w_s2_load;
    logic             w_out_hs;
    logic [63:0]      w_flip;
    logic             w_chk_hit;
    logic             w_syn_nz;
    logic             w_ce;
    logic             w_ue;
    logic [63:0]      w_dec_data;

    assign in_ready  = !r_s1_vld || !r_s2_vld || out_ready;
    assign w_s2_load = r_s1_vld && (!r_s2_vld || out_ready);
    assign w_out_hs  = r_s2_vld && out_ready;
    assign w_in_syn  = SECDED_ECC_pkg::mega_xor(in_code[63:0]) ^ in_code[71:64];

    // in_ready implies stage 1 either empties or moves forward this cycle, so it may be overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_code <= '0;
            r_s1_syn  <= '0;
        end else if (in_ready) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_code <= in_code;
                r_s1_syn  <= w_in_syn;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_col
            localparam logic [7:0] COL = SECDED_ECC_pkg::mega_xor(64'd1 << gi);
            assign w_flip[gi] = (r_s1_syn == COL);
        end
    endgenerate

    assign w_syn_nz   = (r_s1_syn != 8'd0);
    assign w_chk_hit  = w_syn_nz && ((r_s1_syn & (r_s1_syn - 8'd1)) == 8'd0);
    assign w_ce       = (|w_flip) || w_chk_hit;
    assign w_ue       = w_syn_nz && !w_ce;
    assign w_dec_data = r_s1_code[63:0] ^ w_flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld   <= 1'b0;
            r_out_data <= '0;
            r_out_ce   <= 1'b0;
            r_out_ue   <= 1'b0;
            r_out_syn  <= '0;
        end else if (w_s2_load) begin
            r_s2_vld   <= 1'b1;
            r_out_data <= w_dec_data;
            r_out_ce   <= w_ce;
            r_out_ue   <= w_ue;
            r_out_syn  <= r_s1_syn;
        end else if (out_ready) begin
            r_s2_vld <= 1'b0;
        end
    end

    // Clear wins over a coincident delivered word; that word is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ce_cnt    <= '0;
            r_ue_cnt    <= '0;
            r_first_syn <= '0;
            r_ue_seen   <= 1'b0;
        end else if (cnt_clr) begin
            r_ce_cnt    <= '0;
            r_ue_cnt    <= '0;
            r_first_syn <= '0;
            r_ue_seen   <= 1'b0;
        end else if (w_out_hs) begin
            if (r_out_ce && (r_ce_cnt != '1)) begin
                r_ce_cnt <= r_ce_cnt + 1'b1;
            end
            if (r_out_ue && (r_ue_cnt != '1)) begin
                r_ue_cnt <= r_ue_cnt + 1'b1;
            end
            if (r_out_ue && !r_ue_seen) begin
                r_ue_seen   <= 1'b1;
                r_first_syn <= r_out_syn;
            end
        end
    end

    assign out_valid    = r_s2_vld;
    assign out_data     = r_out_data;
    assign out_ce       = r_out_ce;
    assign out_ue       = r_out_ue;
    assign out_syndrome = r_out_syn;
    assign ce_count     = r_ce_cnt;
    assign ue_count     = r_ue_cnt;
    assign first_ue_syn = r_first_syn;
    assign ue_seen      = r_ue_seen;

endmodule

// File: tb/tb_secded_decoder_seq.sv
// Bench for secded_decoder_seq: vector table plus streaming, stall, clear and reset sequences, scored against a queue.
module tb_secded_decoder_seq;
    import SECDED_ECC_pkg::*;

    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [71:0]      in_code = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [63:0]      out_data;
    logic             out_ce;
    logic             out_ue;
    logic [7:0]       out_syndrome;
    logic [CNT_W-1:0] ce_count;
    logic [CNT_W-1:0] ue_count;
    logic [7:0]       first_ue_syn;
    logic             ue_seen;
    logic             cnt_clr = 1'b0;

    always #5 clk = ~clk;

    secded_decoder_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ce(out_ce), .out_ue(out_ue), .out_syndrome(out_syndrome),
        .ce_count(ce_count), .ue_count(ue_count),
        .first_ue_syn(first_ue_syn), .ue_seen(ue_seen), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic [71:0] code;
        logic [63:0] data;
        logic        ce;
        logic        ue;
        logic [7:0]  syn;
    } vec_t;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int         m_ce = 0;
    int         m_ue = 0;
    logic       m_seen = 1'b0;
    logic [7:0] m_first = '0;

    localparam logic [63:0] BASE = 64'h0123_4567_89AB_CDEF;

    function automatic logic [71:0] encode(input logic [63:0] d);
        return {mega_xor(d), d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and statistics model, sampled late in the low clock phase.
    logic held = 1'b0;
    vec_t held_v;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                exp_q.delete();
                m_ce = 0; m_ue = 0; m_seen = 1'b0; m_first = '0;
                held = 1'b0;
            end else begin
                check("ce_count", 64'(ce_count), 64'(m_ce));
                check("ue_count", 64'(ue_count), 64'(m_ue));
                check("ue_seen", 64'(ue_seen), 64'(m_seen));
                check("first_ue_syn", 64'(first_ue_syn), 64'(m_first));
                if (held && out_valid) begin
                    check("stall out_data", out_data, held_v.data);
                    check("stall out_ce", 64'(out_ce), 64'(held_v.ce));
                    check("stall out_ue", 64'(out_ue), 64'(held_v.ue));
                    check("stall out_syndrome", 64'(out_syndrome), 64'(held_v.syn));
                end
                held = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected output: data %h with empty queue", out_data);
                    end else begin
                        vec_t e;
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_ce", 64'(out_ce), 64'(e.ce));
                        check("out_ue", 64'(out_ue), 64'(e.ue));
                        check("out_syndrome", 64'(out_syndrome), 64'(e.syn));
                        if (!cnt_clr) begin
                            if (e.ce && m_ce < SAT) m_ce++;
                            if (e.ue && m_ue < SAT) m_ue++;
                            if (e.ue && !m_seen) begin
                                m_seen = 1'b1;
                                m_first = e.syn;
                            end
                        end
                    end
                end else if (out_valid) begin
                    held = 1'b1;
                    held_v.data = out_data; held_v.ce = out_ce;
                    held_v.ue = out_ue; held_v.syn = out_syndrome;
                end
                if (cnt_clr) begin
                    m_ce = 0; m_ue = 0; m_seen = 1'b0; m_first = '0;
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge after acceptance.
    task automatic send(input vec_t v, output int stalls);
        stalls = 0;
        in_valid = 1'b1;
        in_code = v.code;
        forever begin
            #4;
            if (in_ready) begin
                exp_q.push_back(v);
                @(negedge clk);
                break;
            end
            stalls++;
            @(negedge clk);
            if (stalls > 50) begin
                n_checks++; n_fail++;
                $display("FAIL send timeout: in_ready stuck at %b", in_ready);
                break;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain timeout: %0d words outstanding, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic stat_check(input string tag, input int ce, input int ue, input logic seen, input logic [7:0] first);
        #3;
        check({tag, " ce_count"}, 64'(ce_count), 64'(ce));
        check({tag, " ue_count"}, 64'(ue_count), 64'(ue));
        check({tag, " ue_seen"}, 64'(ue_seen), 64'(seen));
        check({tag, " first_ue_syn"}, 64'(first_ue_syn), 64'(first));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[5];
        vec_t        v;
        logic [71:0] good;
        logic [63:0] d;
        int          st;
        int          tot;
        int          k;
        logic        saw_full;

        good = encode(BASE);
        tbl[0] = '{good, BASE, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{good ^ (72'd1 << 5), BASE, 1'b1, 1'b0, mega_xor(64'h20)};
        tbl[2] = '{good ^ (72'd1 << 70), BASE, 1'b1, 1'b0, 8'h40};
        tbl[3] = '{good ^ 72'h3, 64'h0123_4567_89AB_CDEC, 1'b0, 1'b1, mega_xor(64'h3)};
        tbl[4] = '{good ^ (72'd1 << 10) ^ (72'd1 << 40), BASE ^ (64'd1 << 10) ^ (64'd1 << 40),
                   1'b0, 1'b1, mega_xor((64'd1 << 10) | (64'd1 << 40))};

        // Reset values.
        #2 rst_n = 1'b0;
        #2;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", out_data, 64'd0);
        check("rst out_ce", 64'(out_ce), 64'd0);
        check("rst out_ue", 64'(out_ue), 64'd0);
        check("rst out_syndrome", 64'(out_syndrome), 64'd0);
        check("rst ce_count", 64'(ce_count), 64'd0);
        check("rst ue_count", 64'(ue_count), 64'd0);
        check("rst first_ue_syn", 64'(first_ue_syn), 64'd0);
        check("rst ue_seen", 64'(ue_seen), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, one word at a time.
        for (int i = 0; i < 5; i++) begin
            send(tbl[i], st);
            drain();
        end
        stat_check("table", 2, 2, 1'b1, mega_xor(64'h3));

        // Two-cycle latency on an empty pipeline.
        in_valid = 1'b1; in_code = good;
        #4;
        check("latency accept in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back(tbl[0]);
        @(negedge clk);
        in_valid = 1'b0;
        #3 check("latency N+1 out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #3 check("latency N+2 out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        drain();

        // Clear, then 5 back-to-back CE words: ce_count saturates, no stalls.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        tot = 0;
        for (int b = 0; b < 5; b++) begin
            v = '{good ^ (72'd1 << b), BASE, 1'b1, 1'b0, mega_xor(64'd1 << b)};
            send(v, st);
            tot += st;
        end
        check("throughput stalls", 64'(tot), 64'd0);
        drain();
        stat_check("saturate", 3, 0, 1'b0, 8'h00);

        // Every single-bit error position, streamed.
        for (int b = 0; b < 72; b++) begin
            if (b < 64) v = '{good ^ (72'd1 << b), BASE, 1'b1, 1'b0, mega_xor(64'd1 << b)};
            else        v = '{good ^ (72'd1 << b), BASE, 1'b1, 1'b0, 8'd1 << (b - 64)};
            send(v, st);
        end
        drain();

        // Backpressure: 8 words, out_ready low for cycles 3..5.
        saw_full = 1'b0;
        tot = 0;
        fork
            begin
                for (int w = 0; w < 8; w++) begin
                    d = BASE ^ {32'($urandom), 32'($urandom)} ^ 64'(w);
                    v = '{encode(d), d, 1'b0, 1'b0, 8'h00};
                    send(v, st);
                    tot += st;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 3 && c <= 5);
                    #4;
                    if (!in_ready) saw_full = 1'b1;
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        check("backpressure in_ready dropped", 64'(saw_full), 64'd1);
        check("backpressure stalled sends", 64'(tot > 0), 64'd1);
        drain();

        // First UE latches; a second UE delivered with cnt_clr is dropped.
        send(tbl[3], st);
        drain();
        stat_check("ue latch", 3, 1, 1'b1, mega_xor(64'h3));
        out_ready = 1'b0;
        send(tbl[4], st);
        in_valid = 1'b0;
        k = 0;
        #1;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("clear wait out_valid", 64'(out_valid), 64'd1);
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        stat_check("clear", 0, 0, 1'b0, 8'h00);

        // Asynchronous reset with both stages full.
        send(tbl[1], st);
        drain();
        stat_check("pre-reset", 1, 0, 1'b0, 8'h00);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_code = good;
        repeat (3) @(negedge clk);
        #1;
        check("full in_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset ce_count", 64'(ce_count), 64'd0);
        check("reset out_data", out_data, 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #3 check("post-reset out_valid", 64'(out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
